// File: rtl/rf_access_arbiter_if.sv
// Channel-side and RF-side signal bundle for rf_access_arbiter.
// slave = arbiter view; master = requesters plus the RF port.
interface rf_access_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4
);
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_write;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [NUM_CH-1:0]        ch_gnt;
  logic [NUM_CH-1:0]        ch_done;
  logic [DATA_W-1:0]        ch_rdata;
  logic                     ch_invalid;
  logic                     ch_timeout;
  logic [ADDR_W-1:0]        rf_address;
  logic [DATA_W-1:0]        rf_write_data;
  logic                     rf_read_en;
  logic                     rf_write_en;
  logic [DATA_W-1:0]        rf_read_data;
  logic                     rf_invalid_address;
  logic                     rf_access_complete;
  logic                     rf_proto_err;

  modport slave (
    input  ch_req, ch_write, ch_addr, ch_wdata,
    input  rf_read_data, rf_invalid_address, rf_access_complete,
    output ch_gnt, ch_done, ch_rdata, ch_invalid, ch_timeout,
    output rf_address, rf_write_data, rf_read_en, rf_write_en, rf_proto_err
  );

  modport master (
    output ch_req, ch_write, ch_addr, ch_wdata,
    output rf_read_data, rf_invalid_address, rf_access_complete,
    input  ch_gnt, ch_done, ch_rdata, ch_invalid, ch_timeout,
    input  rf_address, rf_write_data, rf_read_en, rf_write_en, rf_proto_err
  );
endinterface

// File: rtl/rf_access_arbiter.sv
// Round-robin arbiter sharing the HMC register-file port among NUM_CH requesters.
// Define RF_ARB_TIMEOUT_EN to abort accesses that wait longer than TIMEOUT cycles.
module rf_access_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 255
) (
  input logic                clk_hmc,
  input logic                res_hmc,
  rf_access_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [IDX_W-1:0]   last_gnt_reg, last_gnt_next;
  logic               write_reg, write_next;
  logic [ADDR_W-1:0]  addr_reg, addr_next;
  logic [DATA_W-1:0]  wdata_reg, wdata_next;
  logic [NUM_CH-1:0]  gnt_reg, gnt_next;
  logic [NUM_CH-1:0]  done_reg, done_next;
  logic               rd_en_reg, rd_en_next;
  logic               wr_en_reg, wr_en_next;
  logic [DATA_W-1:0]  rdata_reg, rdata_next;
  logic               invalid_reg, invalid_next;
  logic               timeout_reg, timeout_next;
  logic               proto_err_reg, proto_err_next;
  logic               expire;

  logic [ADDR_W-1:0]  addr_arr  [NUM_CH];
  logic [DATA_W-1:0]  wdata_arr [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign addr_arr[gi]  = bus.ch_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = bus.ch_wdata[gi*DATA_W +: DATA_W];
  end

  // Scan from the farthest channel toward the nearest so the first requester
  // after last_gnt is the one left standing.
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int off = NUM_CH; off >= 1; off--) begin
      cand = IDX_W'((int'(last_gnt_reg) + off) % NUM_CH);
      if (bus.ch_req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

`ifdef RF_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] wait_cnt_reg;

  // The count seen in a WAIT cycle is the number of earlier WAIT cycles.
  assign expire = (wait_cnt_reg == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk_hmc) begin
    if (res_hmc) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == S_ISSUE) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == S_WAIT) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end
`else
  logic unused_timeout_param;

  assign expire               = 1'b0;
  assign unused_timeout_param = (TIMEOUT == 0);
`endif

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    last_gnt_next = last_gnt_reg;
    write_next    = write_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    gnt_next      = '0;
    done_next     = '0;
    rd_en_next    = 1'b0;
    wr_en_next    = 1'b0;
    rdata_next    = '0;
    invalid_next  = 1'b0;
    timeout_next  = 1'b0;
    // Completion is only legal while an access is outstanding.
    proto_err_next = proto_err_reg |
                     (bus.rf_access_complete && (state_reg != S_WAIT));

    case (state_reg)
      S_IDLE: begin
        if (pick_valid) begin
          state_next         = S_ISSUE;
          idx_next           = pick_idx;
          write_next         = bus.ch_write[pick_idx];
          addr_next          = addr_arr[pick_idx];
          wdata_next         = wdata_arr[pick_idx];
          gnt_next[pick_idx] = 1'b1;
          rd_en_next         = !bus.ch_write[pick_idx];
          wr_en_next         = bus.ch_write[pick_idx];
        end
      end
      S_ISSUE: begin
        state_next    = S_WAIT;
        last_gnt_next = idx_reg;
      end
      S_WAIT: begin
        if (bus.rf_access_complete) begin
          state_next         = S_RESP;
          done_next[idx_reg] = 1'b1;
          rdata_next         = write_reg ? '0 : bus.rf_read_data;
          invalid_next       = bus.rf_invalid_address;
        end else if (expire) begin
          state_next         = S_RESP;
          done_next[idx_reg] = 1'b1;
          timeout_next       = 1'b1;
        end
      end
      S_RESP: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_hmc) begin
    if (res_hmc) begin
      state_reg     <= S_IDLE;
      idx_reg       <= '0;
      last_gnt_reg  <= IDX_W'(NUM_CH - 1);
      write_reg     <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      gnt_reg       <= '0;
      done_reg      <= '0;
      rd_en_reg     <= 1'b0;
      wr_en_reg     <= 1'b0;
      rdata_reg     <= '0;
      invalid_reg   <= 1'b0;
      timeout_reg   <= 1'b0;
      proto_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      last_gnt_reg  <= last_gnt_next;
      write_reg     <= write_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      gnt_reg       <= gnt_next;
      done_reg      <= done_next;
      rd_en_reg     <= rd_en_next;
      wr_en_reg     <= wr_en_next;
      rdata_reg     <= rdata_next;
      invalid_reg   <= invalid_next;
      timeout_reg   <= timeout_next;
      proto_err_reg <= proto_err_next;
    end
  end

  assign bus.ch_gnt        = gnt_reg;
  assign bus.ch_done       = done_reg;
  assign bus.ch_rdata      = rdata_reg;
  assign bus.ch_invalid    = invalid_reg;
  assign bus.ch_timeout    = timeout_reg;
  assign bus.rf_address    = addr_reg;
  assign bus.rf_write_data = wdata_reg;
  assign bus.rf_read_en    = rd_en_reg;
  assign bus.rf_write_en   = wr_en_reg;
  assign bus.rf_proto_err  = proto_err_reg;
endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed self-checking bench for rf_access_arbiter (4 channels, TIMEOUT=8).
module tb_rf_access_arbiter;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 4;

  logic clk_hmc = 1'b0;
  logic res_hmc;
  int   checks = 0;
  int   errors = 0;
  logic overlap_seen = 1'b0;

  always #5 clk_hmc = ~clk_hmc;

  rf_access_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rf_access_arbiter #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(8)
  ) dut (
    .clk_hmc(clk_hmc),
    .res_hmc(res_hmc),
    .bus    (bus)
  );

  // Strobes and grant/done vectors must never carry more than one bit at once.
  always @(negedge clk_hmc) begin
    if ((bus.rf_read_en && bus.rf_write_en) || !$onehot0(bus.ch_gnt) ||
        !$onehot0(bus.ch_done))
      overlap_seen = 1'b1;
  end

  task automatic tick();
    @(posedge clk_hmc);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_gnt"},   64'(bus.ch_gnt), 64'h0);
    chk({tag, "_done"},  64'(bus.ch_done), 64'h0);
    chk({tag, "_rden"},  64'(bus.rf_read_en), 64'h0);
    chk({tag, "_wren"},  64'(bus.rf_write_en), 64'h0);
    chk({tag, "_addr"},  64'(bus.rf_address), 64'h0);
    chk({tag, "_wdata"}, 64'(bus.rf_write_data), 64'h0);
    chk({tag, "_rdata"}, 64'(bus.ch_rdata), 64'h0);
    chk({tag, "_inv"},   64'(bus.ch_invalid), 64'h0);
    chk({tag, "_tmo"},   64'(bus.ch_timeout), 64'h0);
    chk({tag, "_perr"},  64'(bus.rf_proto_err), 64'h0);
  endtask

  initial begin
    logic [3:0] exp_gnt;

    res_hmc                = 1'b1;
    bus.ch_req             = '0;
    bus.ch_write           = '0;
    bus.ch_addr            = '0;
    bus.ch_wdata           = '0;
    bus.rf_read_data       = '0;
    bus.rf_invalid_address = 1'b0;
    bus.rf_access_complete = 1'b0;
    tick();
    tick();
    chk_idle_outputs("reset");
    res_hmc = 1'b0;
    tick();

    // Ch2 read of address 3; RF answers on the third cycle after the strobe.
    bus.ch_req[2]              = 1'b1;
    bus.ch_write[2]            = 1'b0;
    bus.ch_addr[2*ADDR_W +: 4] = 4'h3;
    tick();
    chk("rd_gnt",  64'(bus.ch_gnt), 64'h4);
    chk("rd_rden", 64'(bus.rf_read_en), 64'h1);
    chk("rd_wren", 64'(bus.rf_write_en), 64'h0);
    chk("rd_addr", 64'(bus.rf_address), 64'h3);
    bus.ch_req[2] = 1'b0;
    tick();
    chk("rd_rden_wait", 64'(bus.rf_read_en), 64'h0);
    chk("rd_addr_hold", 64'(bus.rf_address), 64'h3);
    tick();
    chk("rd_done_early", 64'(bus.ch_done), 64'h0);
    bus.rf_access_complete = 1'b1;
    bus.rf_read_data       = 64'hDEAD_BEEF;
    bus.rf_invalid_address = 1'b0;
    tick();
    bus.rf_access_complete = 1'b0;
    chk("rd_done",  64'(bus.ch_done), 64'h4);
    chk("rd_rdata", 64'(bus.ch_rdata), 64'hDEAD_BEEF);
    chk("rd_inv",   64'(bus.ch_invalid), 64'h0);
    chk("rd_tmo",   64'(bus.ch_timeout), 64'h0);
    $display("txn ch2 read addr=3 rdata=%h invalid=%0b", bus.ch_rdata, bus.ch_invalid);
    tick();
    chk("rd_done_pulse", 64'(bus.ch_done), 64'h0);
    chk("rd_perr", 64'(bus.rf_proto_err), 64'h0);

    // Ch0 write of 0x1234 to address 0xF; RF flags the address invalid.
    bus.ch_req[0]              = 1'b1;
    bus.ch_write[0]            = 1'b1;
    bus.ch_addr[0 +: 4]        = 4'hF;
    bus.ch_wdata[0 +: DATA_W]  = 64'h1234;
    tick();
    chk("wr_gnt",   64'(bus.ch_gnt), 64'h1);
    chk("wr_wren",  64'(bus.rf_write_en), 64'h1);
    chk("wr_rden",  64'(bus.rf_read_en), 64'h0);
    chk("wr_addr",  64'(bus.rf_address), 64'hF);
    chk("wr_wdata", 64'(bus.rf_write_data), 64'h1234);
    bus.ch_req[0] = 1'b0;
    tick();
    chk("wr_wren_wait", 64'(bus.rf_write_en), 64'h0);
    bus.rf_access_complete = 1'b1;
    bus.rf_invalid_address = 1'b1;
    bus.rf_read_data       = 64'hFFFF_0000_FFFF;
    tick();
    bus.rf_access_complete = 1'b0;
    bus.rf_invalid_address = 1'b0;
    chk("wr_done",  64'(bus.ch_done), 64'h1);
    chk("wr_inv",   64'(bus.ch_invalid), 64'h1);
    chk("wr_rdata", 64'(bus.ch_rdata), 64'h0);
    $display("txn ch0 write addr=f wdata=1234 invalid=%0b", bus.ch_invalid);
    tick();
    bus.ch_write = '0;

    // All channels requesting continuously from reset: grants rotate 0,1,2,3,0.
    res_hmc = 1'b1;
    tick();
    res_hmc    = 1'b0;
    bus.ch_req = 4'hF;
    for (int n = 0; n < 5; n++) begin
      exp_gnt = 4'b0001 << (n % 4);
      tick();
      chk("rr_gnt", 64'(bus.ch_gnt), 64'(exp_gnt));
      tick();
      bus.rf_access_complete = 1'b1;
      bus.rf_read_data       = 64'(n + 16);
      tick();
      bus.rf_access_complete = 1'b0;
      chk("rr_done",  64'(bus.ch_done), 64'(exp_gnt));
      chk("rr_rdata", 64'(bus.ch_rdata), 64'(n + 16));
      $display("txn rr step=%0d gnt=%b", n, exp_gnt);
      if (n == 4) bus.ch_req = '0;
      tick();
    end

    // Reset during WAIT drops the access and restores channel-0 priority.
    bus.ch_req = 4'b0010;
    tick();
    chk("rst_gnt1", 64'(bus.ch_gnt), 64'h2);
    bus.ch_req = '0;
    tick();
    res_hmc    = 1'b1;
    bus.ch_req = 4'b1001;
    tick();
    chk_idle_outputs("rst_wait");
    res_hmc = 1'b0;
    tick();
    chk("rst_gnt_ch0", 64'(bus.ch_gnt), 64'h1);
    bus.ch_req = '0;
    tick();
    bus.rf_access_complete = 1'b1;
    bus.rf_read_data       = 64'h55;
    tick();
    bus.rf_access_complete = 1'b0;
    chk("rst_done",  64'(bus.ch_done), 64'h1);
    chk("rst_rdata", 64'(bus.ch_rdata), 64'h55);
    $display("txn ch0 read after reset rdata=%h", bus.ch_rdata);
    tick();

`ifdef RF_ARB_TIMEOUT_EN
    // No completion: eight WAIT cycles, then a timeout response.
    bus.ch_req = 4'b0010;
    tick();
    chk("tmo_gnt", 64'(bus.ch_gnt), 64'h2);
    bus.ch_req = '0;
    for (int w = 0; w < 8; w++) begin
      tick();
      chk("tmo_wait_done", 64'(bus.ch_done), 64'h0);
    end
    tick();
    chk("tmo_done",  64'(bus.ch_done), 64'h2);
    chk("tmo_flag",  64'(bus.ch_timeout), 64'h1);
    chk("tmo_rdata", 64'(bus.ch_rdata), 64'h0);
    chk("tmo_inv",   64'(bus.ch_invalid), 64'h0);
    $display("txn ch1 read timed out");
    tick();
    tick();
    bus.rf_access_complete = 1'b1;
    tick();
    bus.rf_access_complete = 1'b0;
    chk("tmo_late_perr", 64'(bus.rf_proto_err), 64'h1);
`endif

    // Completion while idle raises a sticky protocol error.
    res_hmc = 1'b1;
    tick();
    res_hmc = 1'b0;
    tick();
    chk("perr_clear", 64'(bus.rf_proto_err), 64'h0);
    bus.rf_access_complete = 1'b1;
    tick();
    bus.rf_access_complete = 1'b0;
    chk("perr_rise", 64'(bus.rf_proto_err), 64'h1);
    tick();
    tick();
    tick();
    chk("perr_sticky", 64'(bus.rf_proto_err), 64'h1);
    chk("perr_no_gnt", 64'(bus.ch_gnt), 64'h0);
    chk("perr_no_done", 64'(bus.ch_done), 64'h0);
    $display("txn idle complete proto_err=%0b", bus.rf_proto_err);
    res_hmc = 1'b1;
    tick();
    chk("perr_reset", 64'(bus.rf_proto_err), 64'h0);
    res_hmc = 1'b0;
    tick();

    chk("no_overlap", 64'(overlap_seen), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_access_arbiter.md
# rf_access_arbiter

Multi-channel arbiter that shares the HMC controller register-file (RF) port among `NUM_CH` independent requesters (host configuration, link training sequencer, debug). It accepts one access per grant, drives the single-cycle `rf_read_en`/`rf_write_en` strobe, and waits for `rf_access_complete`. It then returns read data, the invalid-address flag and, optionally, a timeout status to the granted channel. Data width, address width and channel count are parametrised.

## Interface
Parameters:
- `NUM_CH`, 4, number of requesting channels (≥1)
- `DATA_W`, 64, RF data width
- `ADDR_W`, 4, RF address width
- `TIMEOUT`, 255, max WAIT cycles before abort (≥1; used only with `RF_ARB_TIMEOUT_EN`)

Ports (one clock; reset is synchronous and active-high):
- `clk_hmc`  in  1  clock
- `res_hmc`  in  1  synchronous active-high reset
- `ch_req`  in  NUM_CH  per-channel request, level, held until `ch_gnt`
- `ch_write`  in  NUM_CH  1 = write, 0 = read
- `ch_addr`  in  NUM_CH*ADDR_W  packed addresses, channel i at [i*ADDR_W +: ADDR_W]
- `ch_wdata`  in  NUM_CH*DATA_W  packed write data
- `ch_gnt`  out  NUM_CH  one-hot, 1-cycle pulse: request accepted
- `ch_done`  out  NUM_CH  one-hot, 1-cycle pulse: response valid
- `ch_rdata`  out  DATA_W  read data, valid with `ch_done`
- `ch_invalid`  out  1  invalid address, valid with `ch_done`
- `ch_timeout`  out  1  access aborted, valid with `ch_done`
- `rf_address`  out  ADDR_W
- `rf_write_data`  out  DATA_W
- `rf_read_en`  out  1
- `rf_write_en`  out  1
- `rf_read_data`  in  DATA_W
- `rf_invalid_address`  in  1
- `rf_access_complete`  in  1
- `rf_proto_err`  out  1  sticky: `rf_access_complete` seen outside WAIT

## Operation
- FSM: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE, any `ch_req` set:
  - Round-robin pick: first requesting channel after `last_gnt`, wrapping.
  - Latch index, write, addr and wdata from that channel.
  - Go to ISSUE.
- ISSUE, exactly one cycle:
  - Drive `rf_address` and `rf_write_data` from the latch.
  - Assert `rf_write_en` or `rf_read_en`; never both.
  - Pulse `ch_gnt[idx]` and update `last_gnt`.
  - Go to WAIT.
- WAIT:
  - Strobes low; `rf_address`/`rf_write_data` hold.
  - On `rf_access_complete`: capture `rf_read_data` (reads only; writes capture 0) and `rf_invalid_address`, then go to RESP.
- RESP:
  - Pulse `ch_done[idx]` with `ch_rdata`, `ch_invalid` and `ch_timeout` registered.
  - Return to IDLE; new arbitration takes place in IDLE only.
- `rf_access_complete` in IDLE, ISSUE or RESP is ignored and sets `rf_proto_err` until reset.
- Requester holding `ch_req` after its `ch_gnt` is treated as a new request at the next IDLE.
- Reset, including mid-access:
  - FSM → IDLE; the in-flight access is dropped with no `ch_done`.
  - `last_gnt` = NUM_CH-1, so channel 0 wins first.
  - `rf_proto_err` cleared.
- Index width `$clog2(NUM_CH)`, minimum 1 bit.

## Timing
- Reset values: every output 0.
- Request seen in IDLE at cycle T:
  - T+1: ISSUE (`ch_gnt`, strobe)
  - First WAIT cycle: T+2
  - Complete sampled at T+k (k≥2): `ch_done` at T+k+1
- Minimum per-access turnaround is 4 cycles. The next grant is at earliest 2 cycles after `ch_done`: IDLE, then ISSUE.
- All outputs registered; no combinational path from RF inputs to channel outputs.
- Simultaneous requests: one grant per access; with all channels requesting continuously, grants rotate 0,1,2,3,0…

## Configuration
- `RF_ARB_TIMEOUT_EN` defined:
  - WAIT counter of width `$clog2(TIMEOUT+1)`, cleared on WAIT entry, +1 per WAIT cycle.
  - Counter reaching TIMEOUT without complete → RESP with `ch_timeout`=1, `ch_rdata`=0, `ch_invalid`=0.
  - A late complete after abort sets `rf_proto_err`.
  - Complete in the same cycle as expiry wins: normal response.
- Undefined: no counter; WAIT persists until complete; `ch_timeout` tied 0.

## Test plan
- Ch2 reads addr 0x3, RF completes 3 cycles after strobe with data 0xDEAD_BEEF → `rf_read_en` 1 cycle with `rf_address`=3; `ch_done[2]` with `ch_rdata`=0xDEAD_BEEF, `ch_invalid`=0.
- Ch0 writes 0x1234 to addr 0xF, RF returns complete with invalid=1 → `rf_write_en` 1 cycle with `rf_write_data`=0x1234; `ch_done[0]` with `ch_invalid`=1, `ch_rdata`=0.
- All 4 channels request continuously from reset → `ch_gnt` sequence 0,1,2,3,0; never two strobes or two `ch_gnt` bits in one cycle.
- `RF_ARB_TIMEOUT_EN`, TIMEOUT=8, no complete → `ch_done` with `ch_timeout`=1 after 8 WAIT cycles; a complete injected 2 cycles later → `rf_proto_err`=1.
- `res_hmc` asserted during WAIT → next cycle FSM in IDLE, all outputs 0, no `ch_done`; ch3 and ch0 then requesting → ch0 granted first.
- `rf_access_complete` pulsed while idle → `rf_proto_err` rises next cycle and stays high until reset.
